// File: rtl/pairing_arbiter.sv
// Two-requester front end for a shared tate_pairing core: round-robin grant,
// a 2-cycle core reset/load, a RUN phase guarded by a watchdog, and a held response.
module pairing_arbiter #(
  parameter int TIMEOUT = 1000000,
  parameter int TCW     = 20,
  parameter int WIDTH   = 194,
  parameter int W6      = 6*(WIDTH+1)-1
)(
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [WIDTH:0] req0_x1,
  input  logic [WIDTH:0] req0_y1,
  input  logic [WIDTH:0] req0_x2,
  input  logic [WIDTH:0] req0_y2,
  input  logic [WIDTH:0] req1_x1,
  input  logic [WIDTH:0] req1_y1,
  input  logic [WIDTH:0] req1_x2,
  input  logic [WIDTH:0] req1_y2,
  output logic           core_reset,
  output logic [WIDTH:0] core_x1,
  output logic [WIDTH:0] core_y1,
  output logic [WIDTH:0] core_x2,
  output logic [WIDTH:0] core_y2,
  input  logic           core_done,
  input  logic [W6:0]    core_out,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic           rsp_err,
  output logic [W6:0]    rsp_data,
  output logic           busy
);

  if (TCW < 31 && TIMEOUT >= (1 << TCW)) begin : g_tcw_chk
    $error("pairing_arbiter: TCW too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  typedef struct packed {
    logic [WIDTH:0] x1;
    logic [WIDTH:0] y1;
    logic [WIDTH:0] x2;
    logic [WIDTH:0] y2;
  } ops_t;

  state_t         r_state;
  logic           r_last;
  logic           r_owner;
  logic           r_load2;
  logic           r_core_reset;
  logic           r_rsp_valid;
  logic           r_rsp_err;
  logic [TCW-1:0] r_wdog;
  logic [W6:0]    r_rsp_data;
  ops_t           r_ops;

  ops_t [1:0]     w_req_ops;
  logic           w_grant;
  logic           w_accept;
  logic           w_done_ok;
  logic           w_expire;

  assign w_req_ops[0] = {req0_x1, req0_y1, req0_x2, req0_y2};
  assign w_req_ops[1] = {req1_x1, req1_y1, req1_x2, req1_y2};

  // On a tie the requester not served last wins; otherwise whoever is valid.
  assign w_grant  = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_accept = (r_state == IDLE) & reset & (req0_valid | req1_valid);

  assign req0_ready = w_accept & ~w_grant;
  assign req1_ready = w_accept &  w_grant;

  // A zero watchdog marks the first RUN cycle, where done may still be stale.
  assign w_done_ok = core_done & (r_wdog != '0);
  assign w_expire  = (r_wdog == TCW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_load2      <= 1'b0;
      r_core_reset <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_wdog       <= '0;
      r_rsp_data   <= '0;
      r_ops        <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_ops        <= w_req_ops[w_grant];
          r_owner      <= w_grant;
          r_last       <= w_grant;
          r_core_reset <= 1'b1;
          r_load2      <= 1'b0;
          r_state      <= LOAD;
        end
        LOAD: if (r_load2) begin
          r_core_reset <= 1'b0;
          r_wdog       <= '0;
          r_state      <= RUN;
        end else begin
          r_load2      <= 1'b1;
        end
        RUN: if (w_done_ok) begin
          r_rsp_data  <= core_out;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end else if (w_expire) begin
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end else begin
          r_wdog      <= r_wdog + 1'b1;
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_reset = r_core_reset;
  assign core_x1    = r_ops.x1;
  assign core_y1    = r_ops.y1;
  assign core_x2    = r_ops.x2;
  assign core_y2    = r_ops.y2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_owner;
  assign rsp_err    = r_rsp_err;
  assign rsp_data   = r_rsp_data;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_pairing_arbiter.sv
// Directed bench for pairing_arbiter: IDLE grant vectors, a job table driven
// through a core stub, and hand sequences for ties, backpressure, stale done and reset.
module tb_pairing_arbiter;
  localparam int TIMEOUT = 100;
  localparam int TCW     = 8;
  localparam int WIDTH   = 7;
  localparam int W6      = 47;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [WIDTH:0] req0_x1 = '0, req0_y1 = '0, req0_x2 = '0, req0_y2 = '0;
  logic [WIDTH:0] req1_x1 = '0, req1_y1 = '0, req1_x2 = '0, req1_y2 = '0;
  logic           core_reset;
  logic [WIDTH:0] core_x1, core_y1, core_x2, core_y2;
  logic           core_done;
  logic [W6:0]    core_out;
  logic           rsp_valid, rsp_id, rsp_err, busy;
  logic           rsp_ready = 1'b0;
  logic [W6:0]    rsp_data;

  // core stub: done rises stub_delay cycles after core_reset falls (0 = never)
  int          stub_delay = 0;
  int          stub_cnt = 0;
  logic        stub_done = 1'b0, stub_run = 1'b0;
  logic [W6:0] stub_out = '0;
  logic        man_en = 1'b0, man_done = 1'b0;
  logic [W6:0] man_out = '0;

  assign core_done = man_en ? man_done : stub_done;
  assign core_out  = man_en ? man_out  : stub_out;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit         rid;
    logic [7:0] x1, y1, x2, y2;
    int         delay;
    logic [47:0] out;
    bit         eid, eerr;
    logic [47:0] edata;
    int         elat;
  } job_t;

  typedef struct { bit v0, v1, r0, r1; } vec_t;

  job_t jobs[5];
  vec_t vecs[4];
  job_t post_rst;

  pairing_arbiter #(.TIMEOUT(TIMEOUT), .TCW(TCW), .WIDTH(WIDTH), .W6(W6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_x1(req0_x1), .req0_y1(req0_y1), .req0_x2(req0_x2), .req0_y2(req0_y2),
    .req1_x1(req1_x1), .req1_y1(req1_y1), .req1_x2(req1_x2), .req1_y2(req1_y2),
    .core_reset(core_reset),
    .core_x1(core_x1), .core_y1(core_y1), .core_x2(core_x2), .core_y2(core_y2),
    .core_done(core_done), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_reset) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_run  <= 1'b1;
    end else if (stub_run && stub_delay > 0) begin
      if (stub_cnt + 1 == stub_delay) begin
        stub_done <= 1'b1;
        stub_run  <= 1'b0;
      end
      stub_cnt <= stub_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit rid, input bit v, input logic [31:0] ops);
    if (rid) begin
      req1_valid = v;
      {req1_x1, req1_y1, req1_x2, req1_y2} = ops;
    end else begin
      req0_valid = v;
      {req0_x1, req0_y1, req0_x2, req0_y2} = ops;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_core_reset"}, 64'(core_reset), 64'(0));
    chk({tag, "_rsp"}, 64'({rsp_valid, rsp_err, rsp_id}), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_core_ops"}, 64'({core_x1, core_y1, core_x2, core_y2}), 64'(0));
  endtask

  // Entered just after a negedge with the DUT idle; leaves it idle again.
  task automatic run_job(input job_t j);
    logic [31:0] ops;
    int n, lat;
    ops = {j.x1, j.y1, j.x2, j.y2};
    stub_delay = j.delay;
    stub_out   = j.out;
    set_req(j.rid, 1'b1, ops);
    n = 0;
    #1;
    while (!(j.rid ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("job_ready_at_once", 64'(n), 64'(0));
    @(negedge clk);
    set_req(j.rid, 1'b0, ops);
    #1;
    chk("load_c1_core_reset", 64'(core_reset), 64'(1));
    chk("load_c1_ops", 64'({core_x1, core_y1, core_x2, core_y2}), 64'(ops));
    @(negedge clk); #1;
    chk("load_c2_core_reset", 64'(core_reset), 64'(1));
    @(negedge clk); #1;
    chk("run_c3_core_reset", 64'(core_reset), 64'(0));
    lat = 3;
    while (!rsp_valid && lat < 400) begin
      @(negedge clk); #1; lat++;
    end
    chk("job_latency", 64'(lat), 64'(j.elat));
    chk("job_rsp_id", 64'(rsp_id), 64'(j.eid));
    chk("job_rsp_err", 64'(rsp_err), 64'(j.eerr));
    chk("job_rsp_data", 64'(rsp_data), 64'(j.edata));
    chk("job_ops_stable", 64'({core_x1, core_y1, core_x2, core_y2}), 64'(ops));
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk("job_post_hs", 64'({rsp_valid, busy}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n, m, hold_bad;
    logic [W6:0] bp_data;

    vecs[0] = '{v0:0, v1:0, r0:0, r1:0};
    vecs[1] = '{v0:1, v1:0, r0:1, r1:0};
    vecs[2] = '{v0:0, v1:1, r0:0, r1:1};
    vecs[3] = '{v0:1, v1:1, r0:1, r1:0};

    jobs[0] = '{rid:0, x1:8'h01, y1:8'h02, x2:8'h03, y2:8'h04, delay:50,  out:48'h5A,
                eid:0, eerr:0, edata:48'h5A, elat:54};
    jobs[1] = '{rid:1, x1:8'hFF, y1:8'h80, x2:8'h7F, y2:8'h01, delay:1,   out:48'h123456789ABC,
                eid:1, eerr:0, edata:48'h123456789ABC, elat:5};
    jobs[2] = '{rid:0, x1:8'h11, y1:8'h22, x2:8'h33, y2:8'h44, delay:0,   out:48'hDEAD,
                eid:0, eerr:1, edata:48'h0, elat:103};
    jobs[3] = '{rid:1, x1:8'hA5, y1:8'h5A, x2:8'hC3, y2:8'h3C, delay:99,  out:48'hBEEF,
                eid:1, eerr:0, edata:48'hBEEF, elat:103};
    jobs[4] = '{rid:0, x1:8'h0F, y1:8'hF0, x2:8'h55, y2:8'hAA, delay:100, out:48'hCAFE,
                eid:0, eerr:1, edata:48'h0, elat:103};
    post_rst = '{rid:0, x1:8'h9A, y1:8'hBC, x2:8'hDE, y2:8'hF0, delay:10, out:48'h0A0B0C,
                 eid:0, eerr:0, edata:48'h0A0B0C, elat:14};

    // reset with both requesters valid: nothing may be granted
    #1 reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk_reset_outputs("rst");
    @(negedge clk); @(negedge clk); #1;
    chk("rst_hold_ready", 64'({req0_ready, req1_ready}), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // IDLE grant vectors; valids drop before the posedge so nothing is accepted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'({req0_ready, req1_ready}),
          64'({vecs[i].r0, vecs[i].r1}));
      req0_valid = 1'b0; req1_valid = 1'b0;
    end

    // continuous tie, always-ready consumer: grants alternate starting with req0
    @(negedge clk);
    stub_delay = 5; stub_out = 48'h77;
    set_req(0, 1'b1, 32'h01010101);
    set_req(1, 1'b1, 32'h02020202);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(req0_ready | req1_ready) && n < 50) begin
        @(negedge clk); #1; n++;
      end
      chk("tie_one_ready", 64'({req0_ready, req1_ready}), (k % 2) ? 64'(1) : 64'(2));
      m = 0;
      @(negedge clk); #1;
      while (!rsp_valid && m < 50) begin
        @(negedge clk); #1; m++;
      end
      chk("tie_rsp_id", 64'({rsp_valid, rsp_id}), 64'({1'b1, 1'(k % 2)}));
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    // backpressure: response held 10 cycles while req1 waits
    @(negedge clk);
    stub_delay = 3; stub_out = 48'h3C3C;
    set_req(0, 1'b1, 32'h10203040);
    n = 0;
    #1;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    #1;
    m = 0;
    while (!rsp_valid && m < 50) begin @(negedge clk); #1; m++; end
    chk("bp_rsp", 64'({rsp_valid, rsp_id, rsp_err}), 64'({1'b1, 1'b0, 1'b0}));
    bp_data = rsp_data;
    chk("bp_rsp_data", 64'(bp_data), 64'(48'h3C3C));
    hold_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!rsp_valid || rsp_id || rsp_err || rsp_data !== 48'h3C3C || req1_ready)
        hold_bad++;
      @(negedge clk); #1;
    end
    chk("bp_hold_stable", 64'(hold_bad), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_req1_granted", 64'({rsp_valid, req0_ready, req1_ready}), 64'(3'b001));
    req1_valid = 1'b0;

    // stale done held through LOAD and first RUN cycle must not produce a response
    @(negedge clk);
    man_en = 1'b1; man_done = 1'b1; man_out = 48'hEE;
    set_req(0, 1'b1, 32'h0BADF00D);
    n = 0;
    #1;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) req0_valid = 1'b0;
      if (c == 4) man_done = 1'b0;
      if (c == 8) begin man_out = 48'h77; man_done = 1'b1; end
      #1;
      if (c < 9) chk($sformatf("stale_c%0d_no_rsp", c), 64'(rsp_valid), 64'(0));
      else       chk("stale_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'({1'b1, 1'b0, 48'h77}));
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    man_en = 1'b0; man_done = 1'b0;

    // reset mid-RUN abandons the job
    @(negedge clk);
    stub_delay = 20; stub_out = 48'h99;
    set_req(0, 1'b1, 32'hFEDCBA98);
    n = 0;
    #1;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) req0_valid = 1'b0;
    end
    #1 chk("mid_busy_before", 64'(busy), 64'(1));
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    hold_bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy || req0_ready || req1_ready) hold_bad++;
    end
    chk("mid_rst_hold", 64'(hold_bad), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold_bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) hold_bad++;
    end
    chk("mid_rst_no_rsp", 64'(hold_bad), 64'(0));
    run_job(post_rst);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pairing_arbiter.md
PAIRING_ARBITER -- requirements
Module: pairing_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 1000000, max RUN cycles waiting for core_done before the job is aborted.
REQ-002 Parameter: TCW, 20, width of the watchdog counter; the block SHALL require 2^TCW > TIMEOUT.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester N has a job pending.
REQ-006 req0_ready, req1_ready  output  1 each  requester N's operands are accepted this cycle.
REQ-007 reqN_x1, reqN_y1, reqN_x2, reqN_y2 (N=0,1)  input  `WIDTH+1 each  pairing operands, points (x1,y1) and (x2,y2).
REQ-008 core_reset  output  1  active-high synchronous reset/start to the shared tate_pairing core.
REQ-009 core_x1, core_y1, core_x2, core_y2  output  `WIDTH+1 each  registered operands to the core.
REQ-010 core_done  input  1  core level done flag; cleared by core_reset, set when the result is valid.
REQ-011 core_out  input  `W6+1  core result.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  index of the requester owning the response.
REQ-015 rsp_err  output  1  job aborted by watchdog.
REQ-016 rsp_data  output  `W6+1  pairing result (zero when rsp_err=1).
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN and RESP.
REQ-019 IDLE: grant = requester with valid; if both valid, grant the one not granted last (round-robin pointer `last`).
REQ-020 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-021 On valid&ready the block SHALL capture the four operands into core_x1..core_y2, record owner id, set last=owner, go to LOAD.
REQ-022 LOAD SHALL last exactly 2 cycles with core_reset=1, then go to RUN; core_reset=0 in all other states.
REQ-023 core_x1..core_y2 SHALL stay stable from capture until the next capture.
REQ-024 RUN: core_done is ignored in the first RUN cycle (done still clearing); from the second RUN cycle, core_done=1 SHALL capture core_out into rsp_data, set rsp_err=0, go to RESP.
REQ-025 RUN: the watchdog SHALL clear on entry and increment each RUN cycle; on reaching TIMEOUT without core_done it SHALL set rsp_err=1, rsp_data=0, go to RESP.
REQ-026 If core_done and watchdog expiry coincide, the done path wins (rsp_err=0).
REQ-027 RESP: rsp_valid=1 with rsp_id, rsp_err and rsp_data held stable until rsp_valid&rsp_ready, then go to IDLE.
REQ-028 rsp_valid SHALL be 0 outside RESP; no new request is accepted until the response handshake completes.
REQ-029 Latency: acceptance at cycle 0 -> core_reset high cycles 1-2 -> RUN from cycle 3 -> rsp_valid the cycle after the qualifying core_done.
REQ-030 Requester valid deassertion outside IDLE SHALL have no effect; an accepted job always completes.

Reset
REQ-031 reset low SHALL immediately force IDLE, last=1 (req0 wins first tie), watchdog=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, core operands=0, core_reset=0, busy=0, both ready=0 while reset is low.
REQ-032 Reset asserted mid-job SHALL abandon the job without producing a response; the first job after reset SHALL pass through LOAD normally.

Verification
REQ-033 Single job: req0 valid, core stub raises done 50 cycles after core_reset falls with out=0x5A -> req0_ready cycle 0, core_reset high cycles 1-2, rsp_valid with id=0, err=0, data=0x5A.
REQ-034 Tie: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 over four jobs.
REQ-035 Stale done: stub holds core_done=1 from the previous job through LOAD and the first RUN cycle -> no early response; response only after the stub's new done.
REQ-036 Watchdog: TIMEOUT=100, stub never asserts done -> rsp_valid exactly 100 RUN cycles after entering RUN, err=1, data=0.
REQ-037 Backpressure: rsp_ready low 10 cycles during RESP with req1 valid -> rsp fields stable, req1_ready stays 0 until the handshake, then req1 granted.
REQ-038 Reset mid-RUN: reset low 3 cycles -> all outputs at reset values immediately, no response emitted, next req0 job completes normally.
